// File: rtl/truth_table_extractor.sv
// Sweeps a 3-input combinational circuit through rows 000..111, samples its
// output after a settle delay and assembles the 8-bit truth-table code.
module truth_table_extractor #(
   parameter int unsigned SETTLE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] expected,
   input  logic       dut_out,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   output logic       busy,
   output logic       done,
   output logic [7:0] code,
   output logic       pass
);

   localparam int unsigned CW = $clog2(SETTLE + 1);
   localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t          state, state_nx;
   logic [2:0]      idx;
   logic [CW-1:0]   cnt;
   logic [7:0]      shadow;
   logic [7:0]      exp_q;
   logic [2:0]      vec;
   logic [7:0]      final_code;
   logic            accept;
   logic            last;

   assign in1 = vec[2];
   assign in2 = vec[1];
   assign in3 = vec[0];

   // Row 7 lands in bit 0; it is merged here so code updates on the sampling edge.
   assign final_code = {shadow[7:1], dut_out};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      last     = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               accept   = 1'b1;
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (abort) begin
               state_nx = IDLE;
            end else if (cnt == '0 && idx == 3'd7) begin
               last     = 1'b1;
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx    <= '0;
         cnt    <= '0;
         shadow <= '0;
         exp_q  <= '0;
         vec    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         code   <= '0;
         pass   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            idx   <= '0;
            cnt   <= SETTLE_C;
            exp_q <= expected;
            vec   <= '0;
            busy  <= 1'b1;
         end else if (state == WAIT) begin
            if (abort) begin
               busy <= 1'b0;
               vec  <= '0;
            end else if (cnt != '0) begin
               cnt <= cnt - 1'b1;
            end else begin
               shadow[3'd7 - idx] <= dut_out;
               if (last) begin
                  code <= final_code;
                  pass <= (final_code == exp_q);
                  done <= 1'b1;
                  busy <= 1'b0;
                  vec  <= '0;
               end else begin
                  idx <= idx + 3'd1;
                  vec <= idx + 3'd1;
                  cnt <= SETTLE_C;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_truth_table_extractor.sv
// Scoreboard bench: sweeps record the expected {code,pass} at start and the
// per-instance monitors compare on every done pulse.
module tb_truth_table_extractor;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
   logic [7:0] expected_a = '0, expected_b = '0;
   logic       dut_out_a, dut_out_b;
   logic       in1_a, in2_a, in3_a, busy_a, done_a, pass_a;
   logic       in1_b, in2_b, in3_b, busy_b, done_b, pass_b;
   logic [7:0] code_a, code_b;

   logic [7:0] f52 = 8'h52;
   int         mode_a = 0;   // 0: 0x52 direct, 1: tied high, 2: 0x52 with 3-cycle delay
   logic [2:0] d1_a = '0, d2_a = '0, d3_a = '0;
   logic [2:0] d1_b = '0, d2_b = '0, d3_b = '0;

   int checks = 0;
   int errors = 0;
   logic [8:0] q_a[$];
   logic [8:0] q_b[$];

   always #5 clk = ~clk;

   truth_table_extractor #(.SETTLE(4)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .expected(expected_a),
      .dut_out(dut_out_a), .in1(in1_a), .in2(in2_a), .in3(in3_a),
      .busy(busy_a), .done(done_a), .code(code_a), .pass(pass_a));

   truth_table_extractor #(.SETTLE(1)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .expected(expected_b),
      .dut_out(dut_out_b), .in1(in1_b), .in2(in2_b), .in3(in3_b),
      .busy(busy_b), .done(done_b), .code(code_b), .pass(pass_b));

   always @(posedge clk) begin
      d1_a <= {in1_a, in2_a, in3_a};
      d2_a <= d1_a;
      d3_a <= d2_a;
      d1_b <= {in1_b, in2_b, in3_b};
      d2_b <= d1_b;
      d3_b <= d2_b;
   end

   always_comb begin
      dut_out_a = 1'b0;
      case (mode_a)
         0:       dut_out_a = f52[3'd7 - {in1_a, in2_a, in3_a}];
         1:       dut_out_a = 1'b1;
         default: dut_out_a = f52[3'd7 - d3_a];
      endcase
   end
   assign dut_out_b = f52[3'd7 - d3_b];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Row r is sampled at edge (r+1)(s+1); with a d-cycle delay the circuit
   // reflects the vector applied d cycles before that sampling edge.
   function automatic logic [7:0] delayed_code(input int s, input int d);
      logic [7:0] c;
      int k, row;
      c = '0;
      for (int r = 0; r < 8; r++) begin
         k   = (r + 1) * (s + 1) - d - 1;
         row = (k < 0) ? 0 : k / (s + 1);
         c[7 - r] = f52[7 - row];
      end
      return c;
   endfunction

   initial begin
      forever begin
         @(posedge clk); #1;
         if (done_a) begin
            if (q_a.size() == 0) begin
               checks++; errors++;
               $display("FAIL a_unexpected_done: got done=1, required no done");
            end else chk("a_code_pass", {code_a, pass_a}, q_a.pop_front());
         end
         if (done_b) begin
            if (q_b.size() == 0) begin
               checks++; errors++;
               $display("FAIL b_unexpected_done: got done=1, required no done");
            end else chk("b_code_pass", {code_b, pass_b}, q_b.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic start_a_sweep(input logic [7:0] exp, input logic [7:0] c, input logic push);
      @(negedge clk);
      start_a = 1'b1;
      expected_a = exp;
      if (push) q_a.push_back({c, (c == exp)});
      @(posedge clk); #1;
      start_a = 1'b0;
      chk("a_busy_after_start", busy_a, 1);
   endtask

   // Runs edges E0+1..E0+40, checking vector timing and the done edge.
   task automatic body_a(input bit pulse);
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (c % 5 == 1) chk("a_row_vector", {in1_a, in2_a, in3_a}, (c - 1) / 5);
         if (c < 40) chk("a_done_low_in_sweep", done_a, 0);
         else begin
            chk("a_done_at_e40", done_a, 1);
            chk("a_busy_at_e40", busy_a, 0);
            chk("a_inputs_at_e40", {in1_a, in2_a, in3_a}, 0);
         end
         start_a = (pulse && c % 7 == 3);
      end
      start_a = 1'b0;
   endtask

   task automatic full_a(input logic [7:0] exp, input logic [7:0] c, input bit pulse);
      start_a_sweep(exp, c, 1'b1);
      body_a(pulse);
      @(posedge clk); #1;
      chk("a_done_one_cycle", done_a, 0);
   endtask

   initial begin
      int n;
      logic [7:0] cb;
      #2 rst = 1'b1;
      #10;
      chk("rst_inputs", {in1_a, in2_a, in3_a}, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_code", code_a, 8'h00);
      chk("rst_pass", pass_a, 0);
      @(negedge clk) rst = 1'b0;

      mode_a = 0;
      full_a(8'h52, 8'h52, 1'b0);
      full_a(8'hA5, 8'h52, 1'b0);
      mode_a = 1;
      full_a(8'hFF, 8'hFF, 1'b0);
      mode_a = 2;
      repeat (4) @(posedge clk);
      full_a(8'h52, delayed_code(4, 3), 1'b0);

      // abort landing on edge E0+17 leaves the previous 0x52 result in place
      start_a_sweep(8'h00, 8'h00, 1'b0);
      repeat (16) @(posedge clk);
      #1 abort_a = 1'b1;
      @(posedge clk); #1;
      abort_a = 1'b0;
      chk("abort_busy", busy_a, 0);
      chk("abort_inputs", {in1_a, in2_a, in3_a}, 0);
      chk("abort_code_held", code_a, 8'h52);
      chk("abort_pass_held", pass_a, 1);
      repeat (45) @(posedge clk);
      #1 chk("abort_still_idle", busy_a, 0);

      mode_a = 0;
      full_a(8'h52, 8'h52, 1'b0);
      full_a(8'h52, 8'h52, 1'b1);

      // start raised in the done cycle is taken one edge later
      start_a_sweep(8'h52, 8'h52, 1'b1);
      body_a(1'b0);
      @(negedge clk);
      start_a = 1'b1;
      expected_a = 8'h11;
      q_a.push_back({8'h52, 1'b0});
      @(posedge clk); #1;
      chk("restart_done_low", done_a, 0);
      chk("restart_not_yet_busy", busy_a, 0);
      @(posedge clk); #1;
      start_a = 1'b0;
      chk("restart_busy", busy_a, 1);
      body_a(1'b0);
      @(posedge clk); #1;

      // asynchronous reset mid-sweep
      start_a_sweep(8'h52, 8'h00, 1'b0);
      repeat (21) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_code", code_a, 8'h00);
      chk("midrst_pass", pass_a, 0);
      chk("midrst_busy", busy_a, 0);
      chk("midrst_inputs", {in1_a, in2_a, in3_a}, 0);
      @(negedge clk) rst = 1'b0;
      full_a(8'h52, 8'h52, 1'b0);

      // SETTLE=1 with a 3-cycle circuit delay samples stale rows
      cb = delayed_code(1, 3);
      @(negedge clk);
      start_b = 1'b1;
      expected_b = 8'h52;
      q_b.push_back({cb, (cb == 8'h52)});
      @(posedge clk); #1;
      start_b = 1'b0;
      n = 0;
      while (n < 60 && !done_b) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b_done_latency", n, 16);
      chk("b_code_not_52", (code_b != 8'h52), 1);

      repeat (3) @(posedge clk);
      chk("q_a_drained", q_a.size(), 0);
      chk("q_b_drained", q_b.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
